// File: rtl/serial_tx.sv
// ---------------------------------------------------------------------------
// serial_tx : valid/ready parallel-in, async-serial-out transmitter
//             (start, DATA_W bits LSB first, optional even parity, stop)
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  clk_cnt, clk_cnt_n;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              par, par_n;
  logic              tx_out_n;
  logic              bit_end;

  assign bit_end  = (clk_cnt == CNT_LAST);
  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      tx_out  <= 1'b1;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      par     <= par_n;
      tx_out  <= tx_out_n;
    end
  end

  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_n     = par;
    case (state)
      IDLE: begin
        if (tx_valid) begin
          shreg_n   = tx_data;
          par_n     = ^tx_data;
          clk_cnt_n = '0;
          state_n   = START;
        end
      end
      START, PARITY, STOP: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          if (state == START)     state_n = DATA;
          else if (state == STOP) state_n = IDLE;
          else                    state_n = STOP;
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          shreg_n   = shreg >> 1;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_n = '0;
            state_n   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_n = bit_cnt + BIT_W'(1);
          end
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Line level is decoded from the next state so tx_out stays a pure register.
  always_comb begin
    tx_out_n = 1'b1;
    case (state_n)
      START:   tx_out_n = 1'b0;
      DATA:    tx_out_n = shreg_n[0];
      PARITY:  tx_out_n = par_n;
      default: tx_out_n = 1'b1;
    endcase
  end

endmodule

`default_nettype wire
